// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// master: arbiter view; slave: caches plus memory view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] i_rdata;
    logic        i_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [7:0]  mem_data_in  [0:3];
    logic [7:0]  mem_data_out [0:3];

    modport master (
        input  i_req, i_we, i_addr, i_wdata,
        output i_rdata, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done,
        output mem_address, mem_write_en, mem_data_in,
        input  mem_data_out
    );

    modport slave (
        output i_req, i_we, i_addr, i_wdata,
        input  i_rdata, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  mem_address, mem_write_en, mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single word-wide memory port with fixed
// read/write latencies and round-robin tie-breaking.
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.master     bus,
    output logic                   busy
);

    localparam logic [3:0] RdCntInit = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WrCntInit = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_d_q;   // 1: D side owns the port
    logic        last_d_q;    // 1: last completed grant went to D
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  cnt_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    logic        grant;
    logic        grant_d;
    logic        grant_we;
    logic [31:0] grant_addr;
    logic [31:0] grant_wdata;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    grant   = 1'b1;
                    grant_d = bus.d_req && (!bus.i_req || !last_d_q);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign grant_we    = grant_d ? bus.d_we    : bus.i_we;
    assign grant_addr  = grant_d ? bus.d_addr  : bus.i_addr;
    assign grant_wdata = grant_d ? bus.d_wdata : bus.i_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cnt_q     <= 4'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            if (grant) begin
                owner_d_q <= grant_d;
                we_q      <= grant_we;
                addr_q    <= grant_addr;
                wdata_q   <= grant_wdata;
                cnt_q     <= grant_we ? WrCntInit : RdCntInit;
            end else if (state_q == StBusy) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else if (!we_q) begin
                    if (owner_d_q) begin
                        d_rdata_q <= {bus.mem_data_out[0], bus.mem_data_out[1],
                                      bus.mem_data_out[2], bus.mem_data_out[3]};
                    end else begin
                        i_rdata_q <= {bus.mem_data_out[0], bus.mem_data_out[1],
                                      bus.mem_data_out[2], bus.mem_data_out[3]};
                    end
                end
            end
            if (state_q == StDone) begin
                last_d_q <= owner_d_q;
            end
        end
    end

    // Latched command registers double as the held memory-side outputs.
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_en   = (state_q == StBusy) && we_q;
    assign bus.mem_data_in[0] = wdata_q[31:24];
    assign bus.mem_data_in[1] = wdata_q[23:16];
    assign bus.mem_data_in[2] = wdata_q[15:8];
    assign bus.mem_data_in[3] = wdata_q[7:0];

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_done  = (state_q == StDone) && !owner_d_q;
    assign bus.d_done  = (state_q == StDone) && owner_d_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single reads/writes, contention,
// back-to-back grants, reset mid-transaction and early req drop.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .READ_LATENCY  (4),
        .WRITE_LATENCY (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] din_word();
        return {bus.mem_data_in[0], bus.mem_data_in[1], bus.mem_data_in[2], bus.mem_data_in[3]};
    endfunction

    task automatic set_mem(input logic [31:0] w);
        bus.mem_data_out[0] = w[31:24];
        bus.mem_data_out[1] = w[23:16];
        bus.mem_data_out[2] = w[15:8];
        bus.mem_data_out[3] = w[7:0];
    endtask

    // Req must already be high; returns grant-to-done edges and BUSY write cycles.
    task automatic run_txn(input bit dside, input int drop_at, output int cyc,
                           output int we_cyc, output int other_done);
        cyc = 0;
        we_cyc = 0;
        other_done = 0;
        tick();
        while (cyc < 40) begin
            we_cyc += int'(bus.mem_write_en);
            tick();
            cyc++;
            if (drop_at == cyc) begin
                if (dside) bus.d_req = 1'b0;
                else       bus.i_req = 1'b0;
            end
            if (dside ? bus.i_done : bus.d_done) other_done++;
            if (dside ? bus.d_done : bus.i_done) break;
        end
        if (dside) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
    endtask

    task automatic wait_any_done(output int n, output logic who_d, output logic both);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.i_done || bus.d_done) && n < 40);
        who_d = bus.d_done;
        both  = bus.i_done && bus.d_done;
    endtask

    int   cyc, wec, od, n;
    logic who_d, both;

    initial begin
        bus.i_req = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        set_mem(32'h0);

        reset = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_we", {31'b0, bus.mem_write_en}, 32'd0);
        check("rst_addr", bus.mem_address, 32'd0);
        check("rst_done", {30'b0, bus.i_done, bus.d_done}, 32'd0);
        check("rst_i_rdata", bus.i_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_din", din_word(), 32'd0);
        reset = 1'b1;

        // D read
        set_mem(32'hDEADBEEF);
        bus.d_we = 1'b0; bus.d_addr = 32'h0000_1A04; bus.d_req = 1'b1;
        run_txn(1'b1, 0, cyc, wec, od);
        check("d_rd_lat", cyc, 32'd4);
        check("d_rd_we", wec, 32'd0);
        check("d_rd_data", bus.d_rdata, 32'hDEADBEEF);
        check("d_rd_i_done", od, 32'd0);
        check("d_rd_addr", bus.mem_address, 32'h0000_1A04);
        tick();
        check("d_rd_pulse", {31'b0, bus.d_done}, 32'd0);
        check("d_rd_idle", {31'b0, busy}, 32'd0);

        // I write
        bus.i_we = 1'b1; bus.i_addr = 32'h0000_2000; bus.i_wdata = 32'h11223344; bus.i_req = 1'b1;
        run_txn(1'b0, 0, cyc, wec, od);
        check("i_wr_lat", cyc, 32'd5);
        check("i_wr_we_cycles", wec, 32'd5);
        check("i_wr_we_done", {31'b0, bus.mem_write_en}, 32'd0);
        check("i_wr_din", din_word(), 32'h11223344);
        check("i_wr_addr", bus.mem_address, 32'h0000_2000);
        check("i_wr_rdata", bus.i_rdata, 32'd0);
        check("i_wr_d_done", od, 32'd0);
        tick();
        check("i_wr_pulse", {31'b0, bus.i_done}, 32'd0);

        // Contention after reset: D first, then strict alternation
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_mem(32'h01020304);
        bus.i_we = 1'b0; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_any_done(n, who_d, both);
            check("cont_order", {31'b0, who_d}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_overlap", {31'b0, both}, 32'd0);
            if (k > 0) check("cont_spacing", n, 32'd6);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("cont_i_rdata", bus.i_rdata, 32'h01020304);
        check("cont_d_rdata", bus.d_rdata, 32'h01020304);
        tick();
        tick();
        check("cont_idle", {31'b0, busy}, 32'd0);

        // Lone D requester re-granted back to back
        set_mem(32'h55667788);
        bus.d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_any_done(n, who_d, both);
            check("lone_side", {31'b0, who_d}, 32'd1);
            if (k > 0) check("lone_spacing", n, 32'd6);
        end
        bus.d_req = 1'b0;
        tick();

        // Reset at the second BUSY edge of a D write
        bus.d_we = 1'b1; bus.d_addr = 32'h0000_3000; bus.d_wdata = 32'hCAFEF00D; bus.d_req = 1'b1;
        tick();
        tick();
        check("rstw_we_on", {31'b0, bus.mem_write_en}, 32'd1);
        reset = 1'b0;
        bus.d_req = 1'b0;
        tick();
        check("rstw_we_off", {31'b0, bus.mem_write_en}, 32'd0);
        check("rstw_busy", {31'b0, busy}, 32'd0);
        check("rstw_done", {31'b0, bus.d_done}, 32'd0);
        tick();
        check("rstw_done2", {31'b0, bus.d_done}, 32'd0);
        reset = 1'b1;
        set_mem(32'hA5A55A5A);
        bus.d_we = 1'b0; bus.d_addr = 32'h0000_3004; bus.d_req = 1'b1;
        run_txn(1'b1, 0, cyc, wec, od);
        check("rstw_fresh_lat", cyc, 32'd4);
        check("rstw_fresh_data", bus.d_rdata, 32'hA5A55A5A);
        tick();

        // I read with req dropped after one BUSY cycle
        set_mem(32'h0BADF00D);
        bus.i_we = 1'b0; bus.i_addr = 32'h0000_4000; bus.i_req = 1'b1;
        run_txn(1'b0, 1, cyc, wec, od);
        check("drop_lat", cyc, 32'd4);
        check("drop_data", bus.i_rdata, 32'h0BADF00D);
        check("drop_d_rdata", bus.d_rdata, 32'hA5A55A5A);
        check("drop_d_done", od, 32'd0);
        tick();
        check("drop_pulse", {31'b0, bus.i_done}, 32'd0);
        tick();
        check("drop_no_regrant", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
